// File: rtl/conv2d_param_engine.sv
// Multi-channel 2-D convolution layer: zero-padded KxK convolution with bias, rescale, saturation and optional ReLU.
// Produces one output pixel per channel per clock in raster order; results are held until downstream replies.
module conv2d_param_engine #(
    parameter int unsigned BITWIDTH    = 16,
    parameter int unsigned IMG_H       = 28,
    parameter int unsigned IMG_W       = 28,
    parameter int unsigned K           = 5,
    parameter int unsigned PAD         = 2,
    parameter int unsigned NUM_KERNELS = 2,
    parameter int unsigned FRAC_BITS   = 0
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  enable,
    input  logic                                                  relu_en,
    input  logic [IMG_H*IMG_W*BITWIDTH-1:0]                       image,
    input  logic [NUM_KERNELS*K*K*BITWIDTH-1:0]                   kernels,
    input  logic [NUM_KERNELS*BITWIDTH-1:0]                       bias,
    input  logic                                                  reply_from_next_device,
    output logic [NUM_KERNELS*(IMG_H+2*PAD-K+1)*(IMG_W+2*PAD-K+1)*BITWIDTH-1:0] featuremap,
    output logic                                                  finished_for_next_device,
    output logic                                                  busy
);

    localparam int unsigned OUT_H = IMG_H + 2*PAD - K + 1;
    localparam int unsigned OUT_W = IMG_W + 2*PAD - K + 1;
    localparam int unsigned PH    = IMG_H + 2*PAD;
    localparam int unsigned PW    = IMG_W + 2*PAD;
    localparam int unsigned NTAP  = K * K;
    localparam int unsigned ACC_W = 2*BITWIDTH + $clog2(NTAP + 1);
    localparam int unsigned RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int unsigned CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

    state_t state_q;
    state_t state_d;

    // Padded image copy: the border is cleared by reset and never written, so it stays zero.
    logic signed [BITWIDTH-1:0] pad_q  [PH*PW];
    logic signed [BITWIDTH-1:0] ker_q  [NUM_KERNELS*NTAP];
    logic signed [BITWIDTH-1:0] bias_q [NUM_KERNELS];
    logic                       relu_q;
    logic [RW-1:0]              r_q;
    logic [CW-1:0]              c_q;

    logic signed [ACC_W-1:0]    acc_c    [NUM_KERNELS];
    logic signed [ACC_W-1:0]    scaled_c [NUM_KERNELS];
    logic signed [BITWIDTH-1:0] pix_c    [NUM_KERNELS];
    logic                       last_c;
    int unsigned                pix_idx_c;

    assign last_c = (r_q == RW'(OUT_H - 1)) && (c_q == CW'(OUT_W - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = LOAD;
            LOAD:    state_d = COMPUTE;
            COMPUTE: if (last_c) state_d = DONE;
            DONE:    if (reply_from_next_device) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-channel pixel datapath for the current (r,c)
    always_comb begin
        pix_idx_c = 32'(r_q) * OUT_W + 32'(c_q);
        for (int unsigned n = 0; n < NUM_KERNELS; n++) begin
            acc_c[n] = ACC_W'(bias_q[n]);
            for (int unsigned kr = 0; kr < K; kr++) begin
                for (int unsigned kc = 0; kc < K; kc++) begin
                    acc_c[n] = acc_c[n]
                             + ACC_W'(ker_q[n*NTAP + kr*K + kc])
                             * ACC_W'(pad_q[(32'(r_q) + kr)*PW + 32'(c_q) + kc]);
                end
            end
            scaled_c[n] = acc_c[n] >>> FRAC_BITS;
            if (scaled_c[n] > SAT_MAX) begin
                pix_c[n] = SAT_MAX[BITWIDTH-1:0];
            end else if (scaled_c[n] < SAT_MIN) begin
                pix_c[n] = SAT_MIN[BITWIDTH-1:0];
            end else begin
                pix_c[n] = BITWIDTH'(scaled_c[n]);
            end
            if (relu_q && pix_c[n][BITWIDTH-1]) begin
                pix_c[n] = '0;
            end
        end
    end

    // Operand capture, raster counters, featuremap writes and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < PH*PW; i++) pad_q[i] <= '0;
            for (int unsigned i = 0; i < NUM_KERNELS*NTAP; i++) ker_q[i] <= '0;
            for (int unsigned i = 0; i < NUM_KERNELS; i++) bias_q[i] <= '0;
            relu_q                   <= 1'b0;
            r_q                      <= '0;
            c_q                      <= '0;
            featuremap               <= '0;
            finished_for_next_device <= 1'b0;
            busy                     <= 1'b0;
        end else begin
            finished_for_next_device <= (state_d == DONE);
            busy                     <= (state_d == LOAD) || (state_d == COMPUTE);
            case (state_q)
                LOAD: begin
                    for (int unsigned y = 0; y < IMG_H; y++) begin
                        for (int unsigned x = 0; x < IMG_W; x++) begin
                            pad_q[(y + PAD)*PW + x + PAD] <= image[(y*IMG_W + x)*BITWIDTH +: BITWIDTH];
                        end
                    end
                    for (int unsigned i = 0; i < NUM_KERNELS*NTAP; i++) begin
                        ker_q[i] <= kernels[i*BITWIDTH +: BITWIDTH];
                    end
                    for (int unsigned i = 0; i < NUM_KERNELS; i++) begin
                        bias_q[i] <= bias[i*BITWIDTH +: BITWIDTH];
                    end
                    relu_q <= relu_en;
                    r_q    <= '0;
                    c_q    <= '0;
                end
                COMPUTE: begin
                    for (int unsigned n = 0; n < NUM_KERNELS; n++) begin
                        featuremap[(n*OUT_H*OUT_W + pix_idx_c)*BITWIDTH +: BITWIDTH] <= pix_c[n];
                    end
                    if (last_c) begin
                        r_q <= '0;
                        c_q <= '0;
                    end else if (c_q == CW'(OUT_W - 1)) begin
                        c_q <= '0;
                        r_q <= r_q + RW'(1);
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_param_engine.sv
// Scoreboard bench for conv2d_param_engine on a 4x4 image, 3x3 kernels, pad 1, two channels.
// A second instance with FRAC_BITS=8 shares all inputs to exercise the fixed-point rescale.
module tb_conv2d_param_engine;

    localparam int BW  = 16;
    localparam int IH  = 4;
    localparam int IW  = 4;
    localparam int KK  = 3;
    localparam int PD  = 1;
    localparam int NK  = 2;
    localparam int OH  = IH + 2*PD - KK + 1;
    localparam int OW  = IW + 2*PD - KK + 1;
    localparam int FMW = NK*OH*OW*BW;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              relu_en;
    logic [IH*IW*BW-1:0]  image;
    logic [NK*KK*KK*BW-1:0] kernels;
    logic [NK*BW-1:0]  bias;
    logic              reply;
    logic [FMW-1:0]    fm;
    logic [FMW-1:0]    fm8;
    logic              fin;
    logic              fin8;
    logic              busy;
    logic              busy8;

    int img_a [IH*IW];
    int ker_a [NK][KK*KK];
    int bias_a [NK];

    logic [FMW-1:0] exp_q [$];
    logic [FMW-1:0] exp8_q [$];
    logic [FMW-1:0] last_exp;
    logic [FMW-1:0] last_exp8;

    int checks   = 0;
    int failures = 0;

    conv2d_param_engine #(.BITWIDTH(BW), .IMG_H(IH), .IMG_W(IW), .K(KK), .PAD(PD),
                          .NUM_KERNELS(NK), .FRAC_BITS(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .relu_en(relu_en), .image(image),
        .kernels(kernels), .bias(bias), .reply_from_next_device(reply), .featuremap(fm),
        .finished_for_next_device(fin), .busy(busy));

    conv2d_param_engine #(.BITWIDTH(BW), .IMG_H(IH), .IMG_W(IW), .K(KK), .PAD(PD),
                          .NUM_KERNELS(NK), .FRAC_BITS(8)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .relu_en(relu_en), .image(image),
        .kernels(kernels), .bias(bias), .reply_from_next_device(reply), .featuremap(fm8),
        .finished_for_next_device(fin8), .busy(busy8));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int pix(input logic [FMW-1:0] v, input int n, input int r, input int c);
        logic signed [BW-1:0] p;
        p = v[((n*OH + r)*OW + c)*BW +: BW];
        return int'(p);
    endfunction

    task automatic check_fm(input string nm, input logic [FMW-1:0] act, input logic [FMW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < NK*OH*OW; i++) begin
                if (act[i*BW +: BW] !== exp[i*BW +: BW]) begin
                    $display("FAIL %s pixel %0d actual=%0d required=%0d", nm, i,
                             pix(act, 0, 0, i), pix(exp, 0, 0, i));
                    break;
                end
            end
        end
    endtask

    // Reference convolution from the stimulus arrays
    function automatic logic [FMW-1:0] model(input int frac, input bit relu);
        logic [FMW-1:0] m;
        longint acc;
        int y;
        int x;
        m = '0;
        for (int n = 0; n < NK; n++)
            for (int r = 0; r < OH; r++)
                for (int c = 0; c < OW; c++) begin
                    acc = longint'(bias_a[n]);
                    for (int kr = 0; kr < KK; kr++)
                        for (int kc = 0; kc < KK; kc++) begin
                            y = r + kr - PD;
                            x = c + kc - PD;
                            if (y >= 0 && y < IH && x >= 0 && x < IW)
                                acc += longint'(ker_a[n][kr*KK + kc]) * longint'(img_a[y*IW + x]);
                        end
                    acc = acc >>> frac;
                    if (acc > 32767) acc = 32767;
                    if (acc < -32768) acc = -32768;
                    if (relu && acc < 0) acc = 0;
                    m[((n*OH + r)*OW + c)*BW +: BW] = BW'(acc);
                end
        return m;
    endfunction

    // Monitor: compare each presented featuremap against the oldest expectation
    logic fin_d = 1'b0;
    logic fin8_d = 1'b0;
    always @(negedge clk) begin
        if (fin && !fin_d) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_run actual=finished required=idle");
            end else begin
                check_fm("sb_fm", fm, exp_q.pop_front());
            end
        end
        if (fin8 && !fin8_d) begin
            if (exp8_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_run8 actual=finished required=idle");
            end else begin
                check_fm("sb_fm8", fm8, exp8_q.pop_front());
            end
        end
        fin_d  = fin;
        fin8_d = fin8;
    end

    task automatic drive();
        for (int i = 0; i < IH*IW; i++) image[i*BW +: BW] = BW'(img_a[i]);
        for (int n = 0; n < NK; n++) begin
            for (int t = 0; t < KK*KK; t++) kernels[(n*KK*KK + t)*BW +: BW] = BW'(ker_a[n][t]);
            bias[n*BW +: BW] = BW'(bias_a[n]);
        end
    endtask

    task automatic set_img(input bit ramp, input int v);
        for (int i = 0; i < IH*IW; i++) img_a[i] = ramp ? i + 1 : v;
    endtask

    task automatic set_ker(input int n, input int centre, input int others);
        for (int t = 0; t < KK*KK; t++) ker_a[n][t] = (t == (KK*KK)/2) ? centre : others;
    endtask

    // Channel 0 expectation of the form base + sgn*(pixel index + 1)
    task automatic check_ch0(input string nm, input logic [FMW-1:0] v, input int base, input int sgn);
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                check(nm, pix(v, 0, r, c), base + sgn*(r*OW + c + 1));
    endtask

    // One run: issue enable, track latency/busy, optional enable pulse or reset abort
    task automatic do_run(input bit relu, input int pulse_at, input int abort_at);
        int lat;
        int bcnt;
        last_exp  = model(0, relu);
        last_exp8 = model(8, relu);
        exp_q.push_back(last_exp);
        exp8_q.push_back(last_exp8);
        relu_en = relu;
        drive();
        @(negedge clk) enable = 1'b1;
        @(negedge clk) enable = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!fin && lat < 200) begin
            if (busy) bcnt++;
            enable = (lat == pulse_at);
            if (lat == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                exp_q.delete();
                exp8_q.delete();
                check("abort_busy", busy, 0);
                check("abort_fin", fin, 0);
                check("abort_fm_zero", (fm == '0) ? 1 : 0, 1);
                check("abort_fm8_zero", (fm8 == '0) ? 1 : 0, 1);
                return;
            end
            @(negedge clk);
            lat++;
        end
        enable = 1'b0;
        check("latency", lat, OH*OW + 2);
        check("busy_cycles", bcnt, OH*OW + 1);
        check("busy_in_done", busy, 0);
    endtask

    task automatic release_done();
        @(negedge clk) reply = 1'b1;
        @(negedge clk) reply = 1'b0;
        check("fin_after_reply", fin, 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; relu_en = 1'b0; reply = 1'b0;
        set_img(0, 0); set_ker(0, 0, 0); set_ker(1, 0, 0); bias_a[0] = 0; bias_a[1] = 0;
        drive();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_fin", fin, 0);
        check("rst_busy", busy, 0);
        check("rst_fm_zero", (fm == '0) ? 1 : 0, 1);

        // Identity and box filter
        set_img(1, 0); set_ker(0, 1, 0); set_ker(1, 1, 1);
        do_run(0, -1, -1);
        check_ch0("t1_ch0", fm, 0, 1);
        check("t1_ch1_00", pix(fm, 1, 0, 0), 14);
        check("t1_ch1_11", pix(fm, 1, 1, 1), 54);
        check("t1_ch1_33", pix(fm, 1, 3, 3), 54);
        release_done();

        // Saturation both ways
        set_img(0, 32767); set_ker(0, 1, 1); set_ker(1, 1, 0);
        do_run(0, -1, -1);
        check_ch0("t2_pos_sat", fm, 32767, 0);
        release_done();
        set_ker(0, -1, -1);
        do_run(0, -1, -1);
        check_ch0("t2_neg_sat", fm, -32768, 0);
        check("t2_corner", pix(fm, 0, 0, 0), -32768);
        release_done();

        // ReLU and bias
        set_img(1, 0); set_ker(0, -1, 0);
        do_run(1, -1, -1);
        check_ch0("t3_relu", fm, 0, 0);
        release_done();
        do_run(0, -1, -1);
        check_ch0("t3_neg", fm, 0, -1);
        release_done();
        bias_a[0] = 5;
        do_run(0, -1, -1);
        check_ch0("t3_bias", fm, 5, -1);
        release_done();
        bias_a[0] = 0;

        // Fixed-point rescale on the FRAC_BITS=8 instance
        set_img(0, 1); set_ker(0, -1, 0);
        do_run(0, -1, -1);
        check_ch0("t4_floor", fm8, -1, 0);
        release_done();
        set_img(0, 3); set_ker(0, 256, 0);
        do_run(0, -1, -1);
        check_ch0("t4_scale", fm8, 3, 0);
        release_done();

        // Hold in DONE, ignored enables, reply with enable
        set_img(1, 0); set_ker(0, 1, 0); set_ker(1, 1, 1);
        do_run(0, 5, -1);
        for (int i = 0; i < 20; i++) begin
            enable = (i == 3);
            @(negedge clk);
            check("hold_fin", fin, 1);
            check_fm("hold_fm", fm, last_exp);
        end
        enable = 1'b1; reply = 1'b1;
        @(negedge clk);
        enable = 1'b0; reply = 1'b0;
        check("re_fin", fin, 0);
        check("re_busy", busy, 0);
        for (int i = 0; i < 25; i++) @(negedge clk);
        check("re_no_run_busy", busy, 0);
        check("re_no_run_fin", fin, 0);
        check("re_queue_empty", exp_q.size(), 0);

        // Reset in the middle of COMPUTE, then a clean rerun
        do_run(0, -1, 6);
        repeat (2) @(negedge clk);
        check("post_abort_busy", busy, 0);
        do_run(0, -1, -1);
        check_ch0("t6_ch0", fm, 0, 1);
        check("t6_ch1_11", pix(fm, 1, 1, 1), 54);
        release_done();

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size() + exp8_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
